render_layer_compositor: RTL
============================

# render_layer_compositor

Per-pixel layer compositor and layer scheduler for the VGA render path. It takes the 24-bit RGB outputs of up to N sprite/scene renderers (IC-chip players, ? boxes, flags, ground, sky) and selects the winning colour by fixed priority, using the magenta transparency key FF00FF. Per-layer enable and flash configuration arrives over a valid/ready port and is applied only at frame boundaries, so there is no mid-frame tearing. Video sync and data-enable are delayed to match the pixel pipeline.

## Interface
- N_LAYERS, 5, number of layer inputs; layer 0 is highest priority.
- BG_RGB, 24'h5DADE2, colour when no layer is visible (sky blue).
- KEY_RGB, 24'hFF00FF, transparency key.
- VS_ACTIVE, 1'b0, active level of vsync_in.
- FLASH_BIT, 4, frame-counter bit that drives the flash phase (0..5).
- RESET_EN, all ones, value of the enable mask after reset.

- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- de_in  in  1  data enable for the current pixel
- hsync_in  in  1  horizontal sync, passed through
- vsync_in  in  1  vertical sync, passed through; also the frame-boundary source
- layer_rgb_in  in  24*N_LAYERS  layer i occupies bits [24i+23:24i], ordered {r,g,b}
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  compositor can accept a configuration
- cfg_layer_en  in  N_LAYERS  requested enable mask
- cfg_flash_mask  in  N_LAYERS  layers that blink
- rgb_out  out  24  composited pixel
- de_out, hsync_out, vsync_out  out  1 each  delayed syncs
- frame_start  out  1  one-cycle pulse, aligned with the delayed vsync assertion
- win_layer  out  $clog2(N_LAYERS+1)  winning layer index; N_LAYERS means background or blanking

## Operation
- **Frame boundary (fb):** the cycle in which vsync_in becomes VS_ACTIVE after being inactive the previous cycle. Detected against a registered copy of vsync_in.
- **Configuration registers:**
  - Active set: en_act and flash_act.
  - Pending set: en_pend, flash_pend, and a pend_valid flag.
- **Configuration handshake:**
  - cfg_ready = !pend_valid.
  - A transfer happens when cfg_valid && cfg_ready. It loads the pending set and sets pend_valid.
- **Applying configuration at fb:**
  - If pend_valid was set before this cycle, active ← pending and pend_valid clears.
  - A transfer in the same cycle as fb does not apply at this fb. It stays pending until the next fb.
- **Frame counter:**
  - frame_cnt is 6 bits and increments at each fb, wrapping from 63 to 0.
  - flash_phase = frame_cnt[FLASH_BIT].
- **Visibility of layer i:** en_act[i] && !(flash_act[i] && flash_phase) && layer_rgb[i] != KEY_RGB.
- **Winner selection:**
  - The winner is the lowest-index visible layer.
  - If no layer is visible, output BG_RGB with win_layer = N_LAYERS.
  - If the delayed de is 0, output rgb_out = 000000 with win_layer = N_LAYERS, regardless of the layers.
- **Sampling of configuration and flash phase:** the values used for a pixel are those in effect in the cycle that pixel enters stage 1. An fb therefore changes compositing starting with the pixel that arrives in the fb cycle.

## Timing
- **Pipeline, 2 cycles from input to output:**
  - Stage 1 registers layer_rgb_in, the syncs, de, and the per-layer visibility mask.
  - Stage 2 runs the priority encoder and mux into registered outputs.
- **Latency:** rgb_out, de_out, hsync_out, vsync_out, win_layer and frame_start all lag their inputs by exactly 2 cycles. No stalls; one pixel per clock.
- **frame_start:** asserted in the cycle vsync_out first becomes VS_ACTIVE.
- **Reset values:**
  - Outputs: rgb_out = 000000, de_out = 0, hsync_out = vsync_out = !VS_ACTIVE, frame_start = 0, win_layer = N_LAYERS, cfg_ready = 1.
  - Internal: en_act = RESET_EN, flash_act = 0, pend_valid = 0, frame_cnt = 0.
  - The vsync history register resets to VS_ACTIVE, so a reset while vsync is active does not create a false fb.
- **Reset mid-frame:** any pending configuration is discarded and the pipeline contents are flushed to the reset values in the same cycle.
- **cfg_ready:** derived combinationally from pend_valid only, with no combinational path from cfg_valid. The port accepts at most one configuration per frame.

## Test plan
- **Priority:** de=1, layer0=FF00FF, layer1=202020, layer2=C0C0C0, all enabled → 2 cycles later rgb_out=202020, win_layer=1.
- **All transparent:** every layer FF00FF → rgb_out=5DADE2, win_layer=5. Drop de_in=0 → rgb_out=000000 two cycles later.
- **Deferred configuration:** mid-frame transfer cfg_layer_en=5'b11110. Layer0=FF0000 keeps winning until fb. From the fb-cycle pixel on, layer1 wins. cfg_ready stays 0 from the cycle after the transfer until the cycle after fb.
- **Simultaneous events:** cfg transfer in the exact fb cycle → not applied this frame; applied at the following fb.
- **Flash:** flash_mask=5'b00001, FLASH_BIT=0; run 4 frames → layer0 (1E90FF) visible in frames 0 and 2, layer1 wins in frames 1 and 3. frame_start pulses once per frame, 2 cycles after each fb.
- **Reset:** assert reset with a configuration pending and frame_cnt=63 → next cycle all outputs at reset values, cfg_ready=1. The first fb after reset increments frame_cnt to 1.

Source files
------------

// File: rtl/render_layer_compositor.sv
// Fixed-priority compositor for the VGA render path with a frame-boundary-synchronised
// layer enable/flash configuration and a two-stage pixel pipeline.
module render_layer_compositor #(
  parameter int                  N_LAYERS  = 5,
  parameter logic [23:0]         BG_RGB    = 24'h5DADE2,
  parameter logic [23:0]         KEY_RGB   = 24'hFF00FF,
  parameter logic                VS_ACTIVE = 1'b0,
  parameter int                  FLASH_BIT = 4,
  parameter logic [N_LAYERS-1:0] RESET_EN  = '1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              de_in,
  input  logic                              hsync_in,
  input  logic                              vsync_in,
  input  logic [24*N_LAYERS-1:0]            layer_rgb_in,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [N_LAYERS-1:0]               cfg_layer_en,
  input  logic [N_LAYERS-1:0]               cfg_flash_mask,
  output logic [23:0]                       rgb_out,
  output logic                              de_out,
  output logic                              hsync_out,
  output logic                              vsync_out,
  output logic                              frame_start,
  output logic [$clog2(N_LAYERS+1)-1:0]     win_layer
);

  localparam int WIN_W = $clog2(N_LAYERS + 1);

  // Configuration / frame tracking
  logic                vs_hist_q;
  logic                fb;
  logic                xfer;
  logic                apply;
  logic [N_LAYERS-1:0] en_act_q, en_act_d;
  logic [N_LAYERS-1:0] flash_act_q, flash_act_d;
  logic [N_LAYERS-1:0] en_pend_q, en_pend_d;
  logic [N_LAYERS-1:0] flash_pend_q, flash_pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic [5:0]          frame_cnt_q, frame_cnt_d;
  logic [N_LAYERS-1:0] en_eff, flash_eff;
  logic                flash_phase;

  assign fb        = (vsync_in == VS_ACTIVE) && (vs_hist_q != VS_ACTIVE);
  assign cfg_ready = !pend_valid_q;
  assign xfer      = cfg_valid && !pend_valid_q;
  assign apply     = fb && pend_valid_q;

  always_comb begin
    en_act_d     = en_act_q;
    flash_act_d  = flash_act_q;
    en_pend_d    = en_pend_q;
    flash_pend_d = flash_pend_q;
    pend_valid_d = pend_valid_q;
    frame_cnt_d  = frame_cnt_q;
    if (fb) begin
      frame_cnt_d = frame_cnt_q + 6'd1;
    end
    if (apply) begin
      en_act_d     = en_pend_q;
      flash_act_d  = flash_pend_q;
      pend_valid_d = 1'b0;
    end
    // xfer implies no pending set, so it can never collide with apply
    if (xfer) begin
      en_pend_d    = cfg_layer_en;
      flash_pend_d = cfg_flash_mask;
      pend_valid_d = 1'b1;
    end
  end

  // The pixel entering stage 1 during fb already sees the new frame's settings
  assign en_eff      = apply ? en_pend_q    : en_act_q;
  assign flash_eff   = apply ? flash_pend_q : flash_act_q;
  assign flash_phase = frame_cnt_d[FLASH_BIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_hist_q    <= VS_ACTIVE;
      en_act_q     <= RESET_EN;
      flash_act_q  <= '0;
      en_pend_q    <= '0;
      flash_pend_q <= '0;
      pend_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vs_hist_q    <= vsync_in;
      en_act_q     <= en_act_d;
      flash_act_q  <= flash_act_d;
      en_pend_q    <= en_pend_d;
      flash_pend_q <= flash_pend_d;
      pend_valid_q <= pend_valid_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Stage 1
  logic [N_LAYERS-1:0]   vis_d;
  logic [N_LAYERS-1:0]   vis_s1_q;
  logic [24*N_LAYERS-1:0] rgb_s1_q;
  logic                  de_s1_q, hs_s1_q, vs_s1_q, fb_s1_q;

  always_comb begin
    vis_d = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      vis_d[i] = en_eff[i] && !(flash_eff[i] && flash_phase) &&
                 (layer_rgb_in[24*i +: 24] != KEY_RGB);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vis_s1_q <= '0;
      rgb_s1_q <= '0;
      de_s1_q  <= 1'b0;
      hs_s1_q  <= !VS_ACTIVE;
      vs_s1_q  <= !VS_ACTIVE;
      fb_s1_q  <= 1'b0;
    end else begin
      vis_s1_q <= vis_d;
      rgb_s1_q <= layer_rgb_in;
      de_s1_q  <= de_in;
      hs_s1_q  <= hsync_in;
      vs_s1_q  <= vsync_in;
      fb_s1_q  <= fb;
    end
  end

  // Stage 2
  logic [23:0]      rgb_d;
  logic [WIN_W-1:0] win_d;

  always_comb begin
    rgb_d = BG_RGB;
    win_d = WIN_W'(N_LAYERS);
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (vis_s1_q[i]) begin
        rgb_d = rgb_s1_q[24*i +: 24];
        win_d = WIN_W'(i);
      end
    end
    if (!de_s1_q) begin
      rgb_d = '0;
      win_d = WIN_W'(N_LAYERS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out     <= '0;
      win_layer   <= WIN_W'(N_LAYERS);
      de_out      <= 1'b0;
      hsync_out   <= !VS_ACTIVE;
      vsync_out   <= !VS_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      rgb_out     <= rgb_d;
      win_layer   <= win_d;
      de_out      <= de_s1_q;
      hsync_out   <= hs_s1_q;
      vsync_out   <= vs_s1_q;
      frame_start <= fb_s1_q;
    end
  end

endmodule
